// File: rtl/stack_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// stack_ctrl_pkg : opcodes, FSM states, ALU and fault codes for the stack
//                  machine multicycle controller.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package stack_ctrl_pkg;

  localparam logic [3:0] c_OP_ADD  = 4'd0;
  localparam logic [3:0] c_OP_SUB  = 4'd1;
  localparam logic [3:0] c_OP_AND  = 4'd2;
  localparam logic [3:0] c_OP_NOT  = 4'd3;
  localparam logic [3:0] c_OP_PUSH = 4'd4;
  localparam logic [3:0] c_OP_POP  = 4'd5;
  localparam logic [3:0] c_OP_JZ   = 4'd6;
  localparam logic [3:0] c_OP_JMP  = 4'd7;
  localparam logic [3:0] c_OP_NOP  = 4'd8;
  localparam logic [3:0] c_OP_HALT = 4'd9;
  localparam int         c_OP_COUNT = 10;

  typedef enum logic [3:0] {
    FETCH, DECODE, JMP, JZ, PUSH_RD, PUSH_WR, POP_A, LDA,
    POP_WR, POP_B, LDB, ALU, NOT_ALU, PUSH_RES, HALT, FAULT
  } state_t;

  localparam logic [1:0] c_ALU_ADD = 2'b00;
  localparam logic [1:0] c_ALU_SUB = 2'b01;
  localparam logic [1:0] c_ALU_AND = 2'b10;
  localparam logic [1:0] c_ALU_NOT = 2'b11;

  localparam logic [2:0] c_FC_NONE      = 3'b000;
  localparam logic [2:0] c_FC_UNDERFLOW = 3'b001;
  localparam logic [2:0] c_FC_OVERFLOW  = 3'b010;
  localparam logic [2:0] c_FC_ILLEGAL   = 3'b011;
  localparam logic [2:0] c_FC_TIMEOUT   = 3'b100;

  typedef struct packed {
    logic       ldA;
    logic       ldB;
    logic       push;
    logic       pop;
    logic       tos;
    logic       IRWrite;
    logic       memWrite;
    logic       memRead;
    logic       pcWriteCond;
    logic       pcWrite;
    logic       pcSrc;
    logic       IorD;
    logic       srcA;
    logic       srcB;
    logic       MtoS;
    logic [1:0] ALUop;
  } ctl_t;

  function automatic logic is_mem_state(state_t s);
    return (s == FETCH) || (s == PUSH_RD) || (s == POP_WR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/stack_depth_tracker.sv
// ----------------------------------------------------------------------------
// stack_depth_tracker : stack occupancy counter with operand-check flags.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module stack_depth_tracker
  import stack_ctrl_pkg::*;
#(
  parameter int  DEPTH = 16,
  localparam int DW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [DW-1:0] depth,
  output logic          has1,
  output logic          has2,
  output logic          full
);

  logic [DW-1:0] r_depth;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_depth <= '0;
    end else if (inc && !dec) begin
      r_depth <= r_depth + DW'(1);
    end else if (dec && !inc) begin
      r_depth <= r_depth - DW'(1);
    end
  end

  assign depth = r_depth;
  assign has1  = (r_depth != '0);
  assign has2  = (r_depth > DW'(1));
  assign full  = (r_depth == DW'(DEPTH));

endmodule

`default_nettype wire

// File: rtl/stack_mc_ctrl_p.sv
// ----------------------------------------------------------------------------
// stack_mc_ctrl_p : multicycle fetch/decode/execute controller for the stack
//                   datapath with memory handshake, occupancy and fault tracking.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module stack_mc_ctrl_p
  import stack_ctrl_pkg::*;
#(
  parameter int  OP_W        = 4,
  parameter int  DEPTH       = 16,
  parameter int  MEM_TIMEOUT = 15,
  localparam int DW          = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] op,
  input  logic            mem_ready,
  output logic            ldA,
  output logic            ldB,
  output logic            push,
  output logic            pop,
  output logic            tos,
  output logic            IRWrite,
  output logic            memWrite,
  output logic            memRead,
  output logic            pcWriteCond,
  output logic            pcWrite,
  output logic            pcSrc,
  output logic            IorD,
  output logic            srcA,
  output logic            srcB,
  output logic            MtoS,
  output logic [1:0]      ALUop,
  output logic [DW-1:0]   depth,
  output logic            fault,
  output logic [2:0]      fault_code,
  output logic            halted
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  state_t        r_state;
  state_t        w_next;
  logic [WW-1:0] r_wait;
  logic [2:0]    r_code;
  logic [2:0]    w_code;
  ctl_t          w_ctl;
  ctl_t          w_out;
  logic          w_has1;
  logic          w_has2;
  logic          w_full;
  logic          w_illegal;
  logic          w_timeout;
  logic [3:0]    w_op;

  assign w_op      = op[3:0];
  assign w_illegal = (op >= OP_W'(c_OP_COUNT));
  // The counter sits at MEM_TIMEOUT for one cycle; mem_ready in that cycle still completes.
  assign w_timeout = (r_wait == WW'(MEM_TIMEOUT));

  stack_depth_tracker #(
    .DEPTH (DEPTH)
  ) u_depth (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_ctl.push),
    .dec   (w_ctl.pop),
    .depth (depth),
    .has1  (w_has1),
    .has2  (w_has2),
    .full  (w_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= FETCH;
      r_code  <= c_FC_NONE;
      r_wait  <= '0;
    end else begin
      r_state <= w_next;
      r_code  <= w_code;
      if (w_next != r_state) begin
        r_wait <= '0;
      end else if (is_mem_state(r_state) && !mem_ready) begin
        r_wait <= r_wait + WW'(1);
      end
    end
  end

  always_comb begin
    w_next = r_state;
    w_code = r_code;
    case (r_state)
      FETCH, PUSH_RD, POP_WR: begin
        if (mem_ready) begin
          w_next = (r_state == FETCH) ? DECODE : (r_state == PUSH_RD) ? PUSH_WR : FETCH;
        end else if (w_timeout) begin
          w_next = FAULT;
          w_code = c_FC_TIMEOUT;
        end
      end
      DECODE: begin
        if (w_illegal) begin
          w_next = FAULT;
          w_code = c_FC_ILLEGAL;
        end else begin
          case (w_op)
            c_OP_ADD, c_OP_SUB, c_OP_AND: begin
              w_next = w_has2 ? POP_A : FAULT;
              w_code = w_has2 ? r_code : c_FC_UNDERFLOW;
            end
            c_OP_NOT, c_OP_POP: begin
              w_next = w_has1 ? POP_A : FAULT;
              w_code = w_has1 ? r_code : c_FC_UNDERFLOW;
            end
            c_OP_JZ: begin
              w_next = w_has1 ? JZ : FAULT;
              w_code = w_has1 ? r_code : c_FC_UNDERFLOW;
            end
            c_OP_PUSH: begin
              w_next = w_full ? FAULT : PUSH_RD;
              w_code = w_full ? c_FC_OVERFLOW : r_code;
            end
            c_OP_JMP:  w_next = JMP;
            c_OP_NOP:  w_next = FETCH;
            c_OP_HALT: w_next = HALT;
            default: begin
              w_next = FAULT;
              w_code = c_FC_ILLEGAL;
            end
          endcase
        end
      end
      JMP, JZ, PUSH_WR, PUSH_RES: w_next = FETCH;
      POP_A:    w_next = LDA;
      LDA:      w_next = (w_op == c_OP_POP) ? POP_WR : (w_op == c_OP_NOT) ? NOT_ALU : POP_B;
      POP_B:    w_next = LDB;
      LDB:      w_next = ALU;
      ALU, NOT_ALU: w_next = PUSH_RES;
      HALT, FAULT:  w_next = r_state;
      default:  w_next = FAULT;
    endcase
  end

  always_comb begin
    w_ctl = '0;
    case (r_state)
      FETCH: begin
        w_ctl.memRead = 1'b1;
        w_ctl.srcA    = 1'b1;
        w_ctl.srcB    = 1'b1;
        w_ctl.ALUop   = c_ALU_ADD;
        w_ctl.IRWrite = mem_ready;
        w_ctl.pcWrite = mem_ready;
      end
      DECODE:   w_ctl.tos = 1'b1;
      JMP: begin
        w_ctl.pcWrite = 1'b1;
        w_ctl.pcSrc   = 1'b1;
      end
      JZ: begin
        w_ctl.pcWriteCond = 1'b1;
        w_ctl.pcSrc       = 1'b1;
      end
      PUSH_RD: begin
        w_ctl.memRead = 1'b1;
        w_ctl.IorD    = 1'b1;
      end
      PUSH_WR: begin
        w_ctl.push = 1'b1;
        w_ctl.MtoS = 1'b1;
      end
      POP_A, POP_B: w_ctl.pop = 1'b1;
      LDA:      w_ctl.ldA = 1'b1;
      POP_WR: begin
        w_ctl.memWrite = 1'b1;
        w_ctl.IorD     = 1'b1;
      end
      LDB:      w_ctl.ldB = 1'b1;
      ALU:      w_ctl.ALUop = op[1:0];
      NOT_ALU:  w_ctl.ALUop = c_ALU_NOT;
      PUSH_RES: w_ctl.push = 1'b1;
      default:  w_ctl = '0;
    endcase
  end

  // FETCH outputs depend on mem_ready, so gate everything while reset is held.
  assign w_out = rst ? w_ctl : '0;

  assign ldA         = w_out.ldA;
  assign ldB         = w_out.ldB;
  assign push        = w_out.push;
  assign pop         = w_out.pop;
  assign tos         = w_out.tos;
  assign IRWrite     = w_out.IRWrite;
  assign memWrite    = w_out.memWrite;
  assign memRead     = w_out.memRead;
  assign pcWriteCond = w_out.pcWriteCond;
  assign pcWrite     = w_out.pcWrite;
  assign pcSrc       = w_out.pcSrc;
  assign IorD        = w_out.IorD;
  assign srcA        = w_out.srcA;
  assign srcB        = w_out.srcB;
  assign MtoS        = w_out.MtoS;
  assign ALUop       = w_out.ALUop;

  assign fault       = (r_state == FAULT);
  assign fault_code  = r_code;
  assign halted      = (r_state == HALT);

endmodule

`default_nettype wire

// File: tb/tb_stack_mc_ctrl_p.sv
// ----------------------------------------------------------------------------
// tb_stack_mc_ctrl_p : cycle-by-cycle vector bench for stack_mc_ctrl_p.
// Revision: 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_stack_mc_ctrl_p;

  localparam int OP_W        = 4;
  localparam int DEPTH       = 2;
  localparam int MEM_TIMEOUT = 15;
  localparam int DW          = $clog2(DEPTH + 1);

  // Control word bit positions: {ldA .. MtoS, ALUop[1:0]}
  localparam int B_LDA = 16, B_LDB = 15, B_PUSH = 14, B_POP = 13, B_TOS = 12;
  localparam int B_IRW = 11, B_MEMW = 10, B_MEMR = 9, B_PCWC = 8, B_PCW = 7;
  localparam int B_PCSRC = 6, B_IORD = 5, B_SRCA = 4, B_SRCB = 3, B_MTOS = 2;

  localparam logic [16:0] K_F0   = 17'((1 << B_MEMR) | (1 << B_SRCA) | (1 << B_SRCB));
  localparam logic [16:0] K_F1   = 17'((1 << B_MEMR) | (1 << B_SRCA) | (1 << B_SRCB) | (1 << B_IRW) | (1 << B_PCW));
  localparam logic [16:0] K_DEC  = 17'(1 << B_TOS);
  localparam logic [16:0] K_JMP  = 17'((1 << B_PCW) | (1 << B_PCSRC));
  localparam logic [16:0] K_JZ   = 17'((1 << B_PCWC) | (1 << B_PCSRC));
  localparam logic [16:0] K_PRD  = 17'((1 << B_MEMR) | (1 << B_IORD));
  localparam logic [16:0] K_PWR  = 17'((1 << B_PUSH) | (1 << B_MTOS));
  localparam logic [16:0] K_POP  = 17'(1 << B_POP);
  localparam logic [16:0] K_LDA  = 17'(1 << B_LDA);
  localparam logic [16:0] K_POPW = 17'((1 << B_MEMW) | (1 << B_IORD));
  localparam logic [16:0] K_LDB  = 17'(1 << B_LDB);
  localparam logic [16:0] K_ADD  = 17'd0;
  localparam logic [16:0] K_NOT  = 17'd3;
  localparam logic [16:0] K_PRES = 17'(1 << B_PUSH);

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [OP_W-1:0] op = '0;
  logic            mem_ready = 1'b0;
  logic ldA, ldB, push, pop, tos, IRWrite, memWrite, memRead;
  logic pcWriteCond, pcWrite, pcSrc, IorD, srcA, srcB, MtoS;
  logic [1:0]      ALUop;
  logic [DW-1:0]   depth;
  logic            fault;
  logic [2:0]      fault_code;
  logic            halted;
  logic [16:0]     act_ctl;

  always #5 clk = ~clk;

  stack_mc_ctrl_p #(
    .OP_W        (OP_W),
    .DEPTH       (DEPTH),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .op          (op),
    .mem_ready   (mem_ready),
    .ldA         (ldA),
    .ldB         (ldB),
    .push        (push),
    .pop         (pop),
    .tos         (tos),
    .IRWrite     (IRWrite),
    .memWrite    (memWrite),
    .memRead     (memRead),
    .pcWriteCond (pcWriteCond),
    .pcWrite     (pcWrite),
    .pcSrc       (pcSrc),
    .IorD        (IorD),
    .srcA        (srcA),
    .srcB        (srcB),
    .MtoS        (MtoS),
    .ALUop       (ALUop),
    .depth       (depth),
    .fault       (fault),
    .fault_code  (fault_code),
    .halted      (halted)
  );

  assign act_ctl = {ldA, ldB, push, pop, tos, IRWrite, memWrite, memRead,
                    pcWriteCond, pcWrite, pcSrc, IorD, srcA, srcB, MtoS, ALUop};

  typedef struct {
    logic        rst;
    logic [3:0]  op;
    logic        mr;
    logic [16:0] ctl;
    int          dep;
    logic        flt;
    logic [2:0]  code;
    logic        hlt;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic r, input logic [3:0] o, input logic m, input logic [16:0] c,
                     input int d, input logic f, input logic [2:0] fc, input logic h);
    vec_t v;
    v.rst = r; v.op = o; v.mr = m; v.ctl = c; v.dep = d; v.flt = f; v.code = fc; v.hlt = h;
    vecs.push_back(v);
  endtask

  task automatic n(input logic [3:0] o, input logic m, input logic [16:0] c, input int d);
    add(1'b1, o, m, c, d, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic rz(input logic [3:0] o, input logic m);
    add(1'b0, o, m, 17'd0, 0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic fl(input logic [3:0] o, input logic m, input int d, input logic [2:0] fc);
    add(1'b1, o, m, 17'd0, d, 1'b1, fc, 1'b0);
  endtask

  task automatic ins_push(input int d);
    n(4'd4, 1'b1, K_F1, d); n(4'd4, 1'b1, K_DEC, d);
    n(4'd4, 1'b1, K_PRD, d); n(4'd4, 1'b1, K_PWR, d);
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @vec %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  initial begin
    vec_t e;

    // Reset state, including IRWrite held low while mem_ready=1
    rz(4'd0, 1'b0); rz(4'd0, 1'b1);
    // PUSH, PUSH, ADD
    ins_push(0); ins_push(1);
    n(4'd0, 1'b1, K_F1, 2); n(4'd0, 1'b1, K_DEC, 2); n(4'd0, 1'b1, K_POP, 2); n(4'd0, 1'b1, K_LDA, 1);
    n(4'd0, 1'b1, K_POP, 1); n(4'd0, 1'b1, K_LDB, 0); n(4'd0, 1'b1, K_ADD, 0); n(4'd0, 1'b1, K_PRES, 0);
    // JMP, JZ, NOP
    n(4'd7, 1'b1, K_F1, 1); n(4'd7, 1'b1, K_DEC, 1); n(4'd7, 1'b1, K_JMP, 1);
    n(4'd6, 1'b1, K_F1, 1); n(4'd6, 1'b1, K_DEC, 1); n(4'd6, 1'b1, K_JZ, 1);
    n(4'd8, 1'b1, K_F1, 1); n(4'd8, 1'b1, K_DEC, 1);
    // NOT then POP
    n(4'd3, 1'b1, K_F1, 1); n(4'd3, 1'b1, K_DEC, 1); n(4'd3, 1'b1, K_POP, 1);
    n(4'd3, 1'b1, K_LDA, 0); n(4'd3, 1'b1, K_NOT, 0); n(4'd3, 1'b1, K_PRES, 0);
    n(4'd5, 1'b1, K_F1, 1); n(4'd5, 1'b1, K_DEC, 1); n(4'd5, 1'b1, K_POP, 1);
    n(4'd5, 1'b1, K_LDA, 0); n(4'd5, 1'b1, K_POPW, 0);
    // PUSH with two wait cycles in PUSH_RD
    n(4'd4, 1'b1, K_F1, 0); n(4'd4, 1'b1, K_DEC, 0); n(4'd4, 1'b0, K_PRD, 0);
    n(4'd4, 1'b0, K_PRD, 0); n(4'd4, 1'b1, K_PRD, 0); n(4'd4, 1'b1, K_PWR, 0);
    // FETCH stalled three cycles, then PUSH fills the stack
    n(4'd4, 1'b0, K_F0, 1); n(4'd4, 1'b0, K_F0, 1); n(4'd4, 1'b0, K_F0, 1);
    n(4'd4, 1'b1, K_F1, 1); n(4'd4, 1'b1, K_DEC, 1); n(4'd4, 1'b1, K_PRD, 1); n(4'd4, 1'b1, K_PWR, 1);
    // Overflow on the third PUSH with DEPTH=2
    n(4'd4, 1'b1, K_F1, 2); n(4'd4, 1'b1, K_DEC, 2);
    fl(4'd4, 1'b1, 2, 3'b010); fl(4'd4, 1'b0, 2, 3'b010); fl(4'd0, 1'b1, 2, 3'b010);
    // Reset clears the fault; SUB on empty stack underflows
    rz(4'd1, 1'b1);
    n(4'd1, 1'b1, K_F1, 0); n(4'd1, 1'b1, K_DEC, 0);
    fl(4'd1, 1'b1, 0, 3'b001); fl(4'd1, 1'b1, 0, 3'b001);
    // Illegal opcode
    rz(4'd12, 1'b1);
    n(4'd12, 1'b1, K_F1, 0); n(4'd12, 1'b1, K_DEC, 0);
    fl(4'd12, 1'b1, 0, 3'b011); fl(4'd12, 1'b0, 0, 3'b011);
    // Fetch timeout: MEM_TIMEOUT+1 consecutive cycles without mem_ready
    rz(4'd0, 1'b0);
    for (int k = 0; k <= MEM_TIMEOUT; k++) n(4'd0, 1'b0, K_F0, 0);
    fl(4'd0, 1'b0, 0, 3'b100); fl(4'd0, 1'b1, 0, 3'b100);
    // mem_ready arriving as the counter sits at MEM_TIMEOUT completes the fetch
    rz(4'd8, 1'b0);
    for (int k = 0; k < MEM_TIMEOUT; k++) n(4'd8, 1'b0, K_F0, 0);
    n(4'd8, 1'b1, K_F1, 0); n(4'd8, 1'b1, K_DEC, 0); n(4'd8, 1'b1, K_F1, 0);
    // HALT is terminal with all controls low
    rz(4'd9, 1'b1);
    n(4'd9, 1'b1, K_F1, 0); n(4'd9, 1'b1, K_DEC, 0);
    for (int k = 0; k < 22; k++)
      add(1'b1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 17'd0, 0, 1'b0, 3'd0, 1'b1);
    // Reset asserted during POP_B of an AND
    rz(4'd4, 1'b1);
    ins_push(0); ins_push(1);
    n(4'd2, 1'b1, K_F1, 2); n(4'd2, 1'b1, K_DEC, 2); n(4'd2, 1'b1, K_POP, 2); n(4'd2, 1'b1, K_LDA, 1);
    rz(4'd2, 1'b1);
    n(4'd2, 1'b1, K_F1, 0); n(4'd2, 1'b1, K_DEC, 0); fl(4'd2, 1'b1, 0, 3'b001);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      rst       = vecs[i].rst;
      op        = vecs[i].op;
      mem_ready = vecs[i].mr;
      sb.push_back(vecs[i]);
      @(negedge clk);
      e = sb.pop_front();
      chk("ctl",        i, int'(act_ctl),    int'(e.ctl));
      chk("depth",      i, int'(depth),      e.dep);
      chk("fault",      i, int'(fault),      int'(e.flt));
      chk("fault_code", i, int'(fault_code), int'(e.code));
      chk("halted",     i, int'(halted),     int'(e.hlt));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
